instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Program-counter and instruction-fetch front end that feeds the control unit. It holds the PC, fetches instruction words from instruction memory over a req/valid handshake, and presents the latched instruction and its 5-bit opcode. It then samples the control unit's pcSrc and C_offset to choose the next PC: sequential, absolute jump, or PC-relative branch. It detects fetch timeouts and halts on them.

Parameters:
AW, 16, PC / instruction-memory word-address width
IW, 32, instruction width
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 15, maximum number of cycles imem_req may wait for imem_valid before a fault

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
imem_req  out  1  fetch request; held high until accepted
imem_addr  out  AW  fetch word address (equals pc)
imem_rdata  in  IW  fetched instruction word
imem_valid  in  1  imem_rdata valid; counts only while imem_req=1
opcode  out  5  instr[31:27], to control unit
instr  out  IW  latched instruction register
instr_valid  out  1  high while instr is in EXEC (decode/execute window)
pcSrc  in  1  from control unit: 1 = take redirect
C_offset  in  1  from control unit: 0 = absolute jump, 1 = relative branch
stall  in  1  downstream hold; freezes EXEC
pc  out  AW  current instruction address
fetch_err  out  1  sticky timeout fault

Behaviour:
- Single clock CLK. RST is synchronous and active-high. All state updates occur on the posedge of CLK.
- Reset values: pc=RESET_PC, state=FETCH, instr=0, opcode=0, instr_valid=0, fetch_err=0, wait counter=0. While RST=1, imem_req=0.
- FSM states: FETCH, EXEC, HALT.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable; wait counter increments each cycle.
  - On imem_valid=1: instr<=imem_rdata, counter<=0, next state EXEC. A zero-wait memory may assert valid in the same cycle as req.
  - If the counter reaches TIMEOUT without valid: fetch_err<=1, next state HALT, imem_req drops.
- EXEC:
  - imem_req=0; instr_valid=1; opcode=instr[31:27] and remains stable.
  - stall=1: hold state, pc and instr. pcSrc/C_offset are ignored.
  - stall=0: pc<=next_pc, next state FETCH.
  - pcSrc and C_offset are sampled only in an EXEC cycle with stall=0. At any other time they are don't-care.
- next_pc (computed modulo 2^AW, wraps silently):
  - pcSrc=0: pc+1
  - pcSrc=1, C_offset=0: instr[26:0] zero-extended or truncated to AW
  - pcSrc=1, C_offset=1: pc+1+sign_extend(instr[15:0]) truncated to AW
- HALT: all outputs hold, imem_req=0, instr_valid=0. Only RST exits HALT.
- imem_valid while imem_req=0 is ignored; it never corrupts instr.
- Reset mid-fetch cancels the request. The first new request is issued the cycle after RST falls, at RESET_PC.
- Throughput with zero-wait memory: 2 cycles per instruction (FETCH, EXEC).
- The control unit's outputs are combinational from opcode. The one-cycle EXEC window gives them settle time, so no extra pipeline register is required.

Decomposition:
- Shared package proc_defs:
  - opcode constants: AR=5'b00010, I=5'b00001, J=5'b00011, M=5'b00100, T=5'b01011
  - field positions: OPC_HI=31, OPC_LO=27, JADDR 26:0, BOFF 15:0
  - FSM state encoding
- One natural sub-module: next_pc_calc. It is purely combinational: inputs pc, instr, pcSrc, C_offset; output next_pc.

Test Plan:
- Reset then zero-wait memory returning AR words (opcode 00010) -> imem_addr sequence 0,1,2,3; instr_valid high every 2nd cycle; opcode=5'b00010.
- At pc=5, J word with instr[26:0]=0x40 and control unit driving pcSrc=1, C_offset=0 -> next imem_addr=0x0040.
- At pc=0x10, M word with offset 0xFFFE:
  - pcSrc=1, C_offset=1 -> next pc=0x000F
  - pcSrc=0 -> next pc=0x0011
- pc=0xFFFF with a sequential instruction -> next imem_addr=0x0000; with AW=16, a branch offset +2 from pc=0xFFFE -> pc=0x0001.
- Memory returns valid after 3 cycles, and stall=1 for 4 cycles in EXEC:
  - imem_req and imem_addr stay stable while waiting
  - instr/opcode stay stable through the stall
  - a pcSrc glitch during the stall is ignored
  - spurious imem_valid in EXEC leaves instr unchanged
- imem_valid never arrives -> fetch_err=1 after TIMEOUT=15 cycles, state HALT, imem_req=0. Asserting RST for 1 cycle, including mid-fetch -> fetch_err=0 and request restarts at RESET_PC.

Source files
------------

// File: rtl/proc_defs.sv
// Shared definitions for the fetch front end and control unit: opcodes,
// instruction field positions and the fetch FSM state encoding.
package proc_defs;

   localparam logic [4:0] OPC_I  = 5'b00001;
   localparam logic [4:0] OPC_AR = 5'b00010;
   localparam logic [4:0] OPC_J  = 5'b00011;
   localparam logic [4:0] OPC_M  = 5'b00100;
   localparam logic [4:0] OPC_T  = 5'b01011;

   localparam int OPC_HI   = 31;
   localparam int OPC_LO   = 27;
   localparam int JADDR_HI = 26;
   localparam int JADDR_LO = 0;
   localparam int BOFF_HI  = 15;
   localparam int BOFF_LO  = 0;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } fetchState_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, absolute jump, or PC-relative
// branch. All results wrap modulo 2^AW.
module next_pc_calc
   import proc_defs::*;
#(
   parameter int AW = 16
) (
   input  logic [AW-1:0]       pc,
   input  logic [JADDR_HI:0]   instrField,
   input  logic                pcSrc,
   input  logic                C_offset,
   output logic [AW-1:0]       next_pc
);

   logic [AW-1:0] seqPc;
   logic [AW-1:0] jumpPc;
   logic [AW-1:0] branchPc;

   always_comb begin
      seqPc    = pc + AW'(1);
      jumpPc   = AW'(instrField[JADDR_HI:JADDR_LO]);
      // the offset is relative to the following instruction, not to pc itself
      branchPc = seqPc + AW'($signed(instrField[BOFF_HI:BOFF_LO]));
      if (!pcSrc)
         next_pc = seqPc;
      else if (!C_offset)
         next_pc = jumpPc;
      else
         next_pc = branchPc;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC and instruction fetch front end: fetches over a req/valid handshake,
// holds the instruction for one EXEC window, then advances the PC.
module instr_fetch_unit
   import proc_defs::*;
#(
   parameter int            AW       = 16,
   parameter int            IW       = 32,
   parameter logic [AW-1:0] RESET_PC = '0,
   parameter int            TIMEOUT  = 15
) (
   input  logic          CLK,
   input  logic          RST,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic [IW-1:0] imem_rdata,
   input  logic          imem_valid,
   output logic [4:0]    opcode,
   output logic [IW-1:0] instr,
   output logic          instr_valid,
   input  logic          pcSrc,
   input  logic          C_offset,
   input  logic          stall,
   output logic [AW-1:0] pc,
   output logic          fetch_err
);

   localparam int CW = $clog2(TIMEOUT + 1);

   fetchState_t   state;
   logic [AW-1:0] pcReg;
   logic [IW-1:0] instrReg;
   logic          errReg;
   logic [CW-1:0] waitCnt;
   logic [AW-1:0] nextPc;

   next_pc_calc #(.AW(AW)) u_next_pc_calc (
      .pc         (pcReg),
      .instrField (instrReg[JADDR_HI:0]),
      .pcSrc      (pcSrc),
      .C_offset   (C_offset),
      .next_pc    (nextPc)
   );

   // request drops in the same cycle reset is raised so a reset cancels a fetch
   assign imem_req    = (state == FETCH) && !RST;
   assign imem_addr   = pcReg;
   assign pc          = pcReg;
   assign instr       = instrReg;
   assign opcode      = instrReg[OPC_HI:OPC_LO];
   assign instr_valid = (state == EXEC);
   assign fetch_err   = errReg;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= FETCH;
         pcReg    <= RESET_PC;
         instrReg <= '0;
         errReg   <= 1'b0;
         waitCnt  <= '0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_valid) begin
                  instrReg <= imem_rdata;
                  waitCnt  <= '0;
                  state    <= EXEC;
               end else if (waitCnt == CW'(TIMEOUT - 1)) begin
                  errReg <= 1'b1;
                  state  <= HALT;
               end else begin
                  waitCnt <= waitCnt + 1'b1;
               end
            end
            EXEC: begin
               if (!stall) begin
                  pcReg <= nextPc;
                  state <= FETCH;
               end
            end
            HALT: begin
            end
            default: state <= HALT;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a behavioural model checked against the
// DUT every cycle, plus literal expectations at the interesting points.
module tb_instr_fetch_unit;
   import proc_defs::*;

   localparam int AW      = 16;
   localparam int TIMEOUT = 15;
   localparam int M_FETCH = 0;
   localparam int M_EXEC  = 1;
   localparam int M_HALT  = 2;

   logic          CLK;
   logic          RST;
   logic          imem_req;
   logic [15:0]   imem_addr;
   logic [31:0]   imem_rdata;
   logic          imem_valid;
   logic [4:0]    opcode;
   logic [31:0]   instr;
   logic          instr_valid;
   logic          pcSrc;
   logic          C_offset;
   logic          stall;
   logic [15:0]   pc;
   logic          fetch_err;

   int total = 0;
   int bad   = 0;

   logic [31:0] memArr [0:65535];
   int          latency;
   int          memWait = 0;
   logic        spurValid;
   logic [31:0] spurData;

   bit          mInit = 0;
   int          mPc, mMode, mWait;
   logic [31:0] mInstr;
   logic        mErr;

   instr_fetch_unit #(.AW(16), .IW(32), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_valid  (imem_valid),
      .opcode      (opcode),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pcSrc       (pcSrc),
      .C_offset    (C_offset),
      .stall       (stall),
      .pc          (pc),
      .fetch_err   (fetch_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // memory: answers after `latency` waiting cycles, never when latency < 0
   assign imem_valid = spurValid | (imem_req && (latency >= 0) && (memWait >= latency));
   assign imem_rdata = spurValid ? spurData : memArr[imem_addr];
   always @(posedge CLK) memWait <= (imem_req && !imem_valid) ? memWait + 1 : 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int nextPcModel(int p, logic [31:0] w, logic s, logic c);
      if (!s) return (p + 1) & 'hFFFF;
      if (!c) return int'(w[26:0]) & 'hFFFF;
      return (p + 1 + int'($signed(w[15:0]))) & 'hFFFF;
   endfunction

   function automatic logic [31:0] jw(input logic [26:0] t);
      return {OPC_J, t};
   endfunction

   always @(posedge CLK) begin
      if (RST) begin
         mInit = 1; mPc = 0; mInstr = 0; mMode = M_FETCH; mWait = 0; mErr = 0;
      end else if (mInit) begin
         case (mMode)
            M_FETCH: begin
               if (imem_valid) begin
                  mInstr = imem_rdata; mMode = M_EXEC; mWait = 0;
               end else begin
                  mWait++;
                  if (mWait >= TIMEOUT) begin mErr = 1; mMode = M_HALT; end
               end
            end
            M_EXEC: if (!stall) begin
               mPc = nextPcModel(mPc, mInstr, pcSrc, C_offset);
               mMode = M_FETCH;
            end
            default: ;
         endcase
      end
   end

   always @(negedge CLK) begin
      if (mInit) begin
         check("req",       32'(imem_req),    32'((mMode == M_FETCH) && !RST));
         check("addr",      32'(imem_addr),   mPc);
         check("pc",        32'(pc),          mPc);
         check("instr",     instr,            mInstr);
         check("opcode",    32'(opcode),      32'(mInstr[31:27]));
         check("ivalid",    32'(instr_valid), 32'(mMode == M_EXEC));
         check("fetch_err", 32'(fetch_err),   32'(mErr));
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic runToExec(input logic [15:0] tgt);
      int n = 0;
      while (!(mMode == M_EXEC && mPc == int'(tgt)) && n < 60) begin
         cyc();
         n++;
      end
      check("reach_exec", 32'({instr_valid, pc}), 32'({1'b1, tgt}));
   endtask

   task automatic takeJump();
      pcSrc = 1'b1; C_offset = 1'b0;
      cyc();
      pcSrc = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; stall = 1'b0; pcSrc = 1'b0; C_offset = 1'b0;
      latency = 0; spurValid = 1'b0; spurData = '0;
      for (int a = 0; a < 65536; a++) memArr[a] = {OPC_AR, 27'(a)};

      cyc(); cyc(); #1;
      check("rst_pc",     32'(pc),          32'h0);
      check("rst_instr",  instr,            32'h0);
      check("rst_ivalid", 32'(instr_valid), 32'h0);
      check("rst_err",    32'(fetch_err),   32'h0);
      check("rst_req",    32'(imem_req),    32'h0);

      RST = 1'b0;
      #1;
      check("first_req",  32'(imem_req),  32'h1);
      check("first_addr", 32'(imem_addr), 32'h0);
      for (int k = 1; k <= 3; k++) begin
         cyc(); #1;
         check("seq_ivalid_hi", 32'(instr_valid), 32'h1);
         check("seq_opcode",    32'(opcode),      32'(5'b00010));
         cyc(); #1;
         check("seq_addr",      32'(imem_addr),   32'(k));
         check("seq_ivalid_lo", 32'(instr_valid), 32'h0);
      end

      memArr[0]      = jw(27'h0FFFE);
      memArr[1]      = jw(27'h00123);
      memArr[5]      = jw(27'h00040);
      memArr[16'h40] = jw(27'h00010);
      memArr[16'h10] = {OPC_M, 11'd0, 16'hFFFE};
      memArr[16'h0F] = jw(27'h00010);
      memArr[16'h11] = jw(27'h0FFFF);
      memArr[16'hFFFE] = {OPC_M, 11'd0, 16'h0002};

      runToExec(16'h0005);
      takeJump(); #1;
      check("jump_addr", 32'(imem_addr), 32'h0040);

      runToExec(16'h0040);
      takeJump();
      runToExec(16'h0010);
      check("m_opcode", 32'(opcode), 32'(5'b00100));
      pcSrc = 1'b1; C_offset = 1'b1;
      cyc();
      pcSrc = 1'b0; C_offset = 1'b0; #1;
      check("branch_back_pc", 32'(pc), 32'h000F);
      check("model_pin_0f",   mPc,     32'h000F);

      runToExec(16'h000F);
      takeJump();
      runToExec(16'h0010);
      cyc(); #1;
      check("seq_after_m_pc", 32'(pc), 32'h0011);

      runToExec(16'h0011);
      takeJump();
      runToExec(16'hFFFF);
      cyc(); #1;
      check("wrap_seq_addr", 32'(imem_addr), 32'h0000);

      runToExec(16'h0000);
      takeJump();
      runToExec(16'hFFFE);
      pcSrc = 1'b1; C_offset = 1'b1; latency = 3;
      cyc();
      pcSrc = 1'b0; C_offset = 1'b0; #1;
      check("wrap_branch_pc", 32'(pc),       32'h0001);
      check("wait_req_1",     32'(imem_req), 32'h1);
      check("model_pin_01",   mPc,           32'h0001);

      for (int k = 0; k < 3; k++) begin
         cyc(); #1;
         check("wait_req",    32'(imem_req),    32'h1);
         check("wait_addr",   32'(imem_addr),   32'h0001);
         check("wait_ivalid", 32'(instr_valid), 32'h0);
      end
      stall = 1'b1;
      cyc(); #1;
      check("stall_ivalid", 32'(instr_valid), 32'h1);
      check("stall_instr",  instr,            32'h18000123);
      pcSrc = 1'b1; C_offset = 1'b0;
      cyc();
      spurValid = 1'b1; spurData = 32'hDEADBEEF;
      cyc();
      spurValid = 1'b0; pcSrc = 1'b0;
      cyc(); #1;
      check("stall_hold_instr", instr,         32'h18000123);
      check("stall_hold_pc",    32'(pc),       32'h0001);
      check("stall_opcode",     32'(opcode),   32'(5'b00011));
      cyc();
      stall = 1'b0; latency = -1;
      cyc(); #1;
      check("after_stall_pc", 32'(pc), 32'h0002);

      repeat (14) cyc();
      #1;
      check("pre_timeout_err", 32'(fetch_err), 32'h0);
      check("pre_timeout_req", 32'(imem_req),  32'h1);
      cyc(); #1;
      check("timeout_err",    32'(fetch_err),   32'h1);
      check("timeout_req",    32'(imem_req),    32'h0);
      check("timeout_ivalid", 32'(instr_valid), 32'h0);
      check("timeout_pc",     32'(pc),          32'h0002);
      repeat (3) cyc();
      #1;
      check("halt_err", 32'(fetch_err), 32'h1);
      check("halt_req", 32'(imem_req),  32'h0);

      RST = 1'b1; #1;
      check("rst_in_halt_req", 32'(imem_req), 32'h0);
      cyc();
      RST = 1'b0; #1;
      check("restart_req",  32'(imem_req),  32'h1);
      check("restart_addr", 32'(imem_addr), 32'h0);
      check("restart_err",  32'(fetch_err), 32'h0);

      repeat (5) cyc();
      #1;
      check("midfetch_req", 32'(imem_req), 32'h1);
      RST = 1'b1; #1;
      check("midfetch_cancel", 32'(imem_req), 32'h0);
      cyc();
      RST = 1'b0; latency = 0; #1;
      check("midfetch_restart_req",  32'(imem_req),  32'h1);
      check("midfetch_restart_addr", 32'(imem_addr), 32'h0);
      repeat (6) cyc();
      #1;
      check("final_seq_addr", 32'(imem_addr), 32'h0003);
      cyc(); cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
